// File: rtl/ahb_edge_pkg.sv
// ---------------------------------------------------------------------------
// ahb_edge_pkg
// Shared types and constants for the edge-filter output write path.
//   wr_state_t       : sequencing states of address_update_w
//   KERNEL_BORDER    : rows/cols lost to the 3x3 kernel border
//   calc_out_pixels  : output pixel count for an input image
// ---------------------------------------------------------------------------
package ahb_edge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } wr_state_t;

    localparam logic [15:0] KERNEL_BORDER = 16'd2;

    // Images narrower than the kernel produce no output at all.
    function automatic logic [31:0] calc_out_pixels(input logic [15:0] len,
                                                    input logic [15:0] wid);
        logic [15:0] cols;
        logic [15:0] rows;
        cols = len - KERNEL_BORDER;
        rows = wid - KERNEL_BORDER;
        if (len < 16'd3 || wid < 16'd3)
            return 32'd0;
        return {16'd0, cols} * {16'd0, rows};
    endfunction

endpackage

// File: rtl/address_update_w_pixel_packer.sv
// ---------------------------------------------------------------------------
// pixel_packer
// Packs accepted 8-bit pixels little-endian into 32-bit words. A word is
// complete on its 4th byte or on the last pixel of the image; unused upper
// bytes stay zero. A completed word either leaves on the same edge (i_take)
// or is parked here (o_full) until the caller can take it.
//   HCLK, HRESETn : clock, async active-low reset
//   i_clear       : drop any contents (new image)
//   i_accept      : pixel i_pix is accepted this cycle
//   i_last        : the accepted pixel is the last of the image
//   i_take        : caller moves the completed word out on this edge
//   o_word        : completed word (parked word, or word completing now)
//   o_word_done   : a completed word is available this cycle
//   o_full        : a completed word is parked
//   o_empty       : no bytes held
// ---------------------------------------------------------------------------
module pixel_packer (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        i_clear,
    input  logic        i_accept,
    input  logic [7:0]  i_pix,
    input  logic        i_last,
    input  logic        i_take,
    output logic [31:0] o_word,
    output logic        o_word_done,
    output logic        o_full,
    output logic        o_empty
);

    logic [31:0] r_data;
    logic [1:0]  r_lane;
    logic        r_full;

    logic [31:0] w_merged;
    logic        w_complete;

    always_comb begin
        w_merged = r_data;
        w_merged[{r_lane, 3'b000} +: 8] = i_pix;
    end

    assign w_complete  = i_accept && ((r_lane == 2'd3) || i_last);
    assign o_word      = r_full ? r_data : w_merged;
    assign o_word_done = r_full || w_complete;
    assign o_full      = r_full;
    assign o_empty     = !r_full && (r_lane == 2'd0);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_data <= 32'd0;
            r_lane <= 2'd0;
            r_full <= 1'b0;
        end else if (i_clear || i_take) begin
            // Clearing the data here is what zero-fills a short last word.
            r_data <= 32'd0;
            r_lane <= 2'd0;
            r_full <= 1'b0;
        end else if (w_complete) begin
            r_data <= w_merged;
            r_full <= 1'b1;
        end else if (i_accept) begin
            r_data <= w_merged;
            r_lane <= r_lane + 2'd1;
        end
    end

endmodule

// File: rtl/address_update_w.sv
// ---------------------------------------------------------------------------
// address_update_w
// Collects processed pixels of one output image, packs them into words and
// issues word writes to consecutive addresses from out_addr.
//   HCLK, HRESETn          : clock, async active-low reset
//   out_addr, length, width: image parameters, sampled on accepted start
//   start                  : begin a new image (only honoured in IDLE)
//   pix_valid/pix_data     : pixel stream in; pix_ready accepts
//   wr_req/wr_addr/wr_data : word write request, held until wr_done
//   wr_done                : write completed (ignored when wr_req low)
//   busy                   : not IDLE
//   image_done             : one-cycle pulse when all words are written
//
// state  | meaning
// IDLE   | waiting for start
// ACTIVE | accepting pixels, writing completed words
// FLUSH  | all pixels in, draining parked/held words
// DONE   | image finished, image_done high for this cycle
// ---------------------------------------------------------------------------
module address_update_w
    import ahb_edge_pkg::*;
(
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] out_addr,
    input  logic [15:0] length,
    input  logic [15:0] width,
    input  logic        start,
    input  logic        pix_valid,
    input  logic [7:0]  pix_data,
    output logic        pix_ready,
    output logic        wr_req,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    input  logic        wr_done,
    output logic        busy,
    output logic        image_done
);

    wr_state_t   r_state;
    logic [31:0] r_base;
    logic [31:0] r_npix;
    logic [31:0] r_pix_cnt;
    logic [31:0] r_word_idx;
    logic [31:0] r_hold_data;
    logic        r_hold_valid;

    logic [31:0] w_npix_in;
    logic        w_start;
    logic        w_accept;
    logic        w_last;
    logic        w_wr_done;
    logic        w_move;
    logic [31:0] w_word;
    logic        w_word_done;
    logic        w_pack_full;
    logic        w_pack_empty;

    assign w_npix_in = calc_out_pixels(length, width);
    assign w_start   = start && (r_state == IDLE);
    assign w_accept  = pix_valid && pix_ready;
    assign w_last    = w_accept && (r_pix_cnt == r_npix - 32'd1);
    assign w_wr_done = wr_done && r_hold_valid;
    // A completed word enters hold when hold is free or frees on this edge.
    assign w_move    = w_word_done && (!r_hold_valid || w_wr_done);

    pixel_packer u_packer (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .i_clear     (w_start),
        .i_accept    (w_accept),
        .i_pix       (pix_data),
        .i_last      (w_last),
        .i_take      (w_move),
        .o_word      (w_word),
        .o_word_done (w_word_done),
        .o_full      (w_pack_full),
        .o_empty     (w_pack_empty)
    );

    assign pix_ready  = (r_state == ACTIVE) && !w_pack_full;
    assign wr_req     = r_hold_valid;
    // Words leave strictly in order, so hold always carries word r_word_idx.
    assign wr_addr    = r_base + (r_word_idx << 2);
    assign wr_data    = r_hold_data;
    assign busy       = (r_state != IDLE);
    assign image_done = (r_state == DONE);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_hold_valid <= 1'b0;
            r_hold_data  <= 32'd0;
        end else if (w_move) begin
            r_hold_valid <= 1'b1;
            r_hold_data  <= w_word;
        end else if (w_wr_done) begin
            r_hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state    <= IDLE;
            r_base     <= 32'd0;
            r_npix     <= 32'd0;
            r_pix_cnt  <= 32'd0;
            r_word_idx <= 32'd0;
        end else begin
            if (w_wr_done)
                r_word_idx <= r_word_idx + 32'd1;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_base     <= out_addr & 32'hFFFF_FFFC;
                        r_npix     <= w_npix_in;
                        r_pix_cnt  <= 32'd0;
                        r_word_idx <= 32'd0;
                        r_state    <= (w_npix_in == 32'd0) ? DONE : ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (w_accept)
                        r_pix_cnt <= r_pix_cnt + 32'd1;
                    if (w_last)
                        r_state <= FLUSH;
                end
                FLUSH: begin
                    if (!r_hold_valid && w_pack_empty)
                        r_state <= DONE;
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_address_update_w.sv
module tb_address_update_w;

    logic        HCLK;
    logic        HRESETn;
    logic [31:0] out_addr;
    logic [15:0] length;
    logic [15:0] width;
    logic        start;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        pix_ready;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_done;
    logic        busy;
    logic        image_done;

    int n_tests = 0;
    int n_fail  = 0;

    address_update_w dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .out_addr   (out_addr),
        .length     (length),
        .width      (width),
        .start      (start),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_ready  (pix_ready),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_done    (wr_done),
        .busy       (busy),
        .image_done (image_done)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    typedef struct {
        logic [15:0]       len;
        logic [15:0]       wid;
        logic [31:0]       addr;
        logic [7:0]        pix0;
        logic [7:0]        step;
        int                npix;
        int                nwords;
        int                delay;
        bit                exp_stall;
        bit                restart;
        logic [2:0][31:0]  exp_addr;
        logic [2:0][31:0]  exp_data;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] len, input logic [15:0] wid,
                                input logic [31:0] addr, input logic [7:0] p0,
                                input logic [7:0] st, input int np, input int nw,
                                input int dly, input bit stall, input bit rs,
                                input logic [31:0] a0, input logic [31:0] d0,
                                input logic [31:0] a1, input logic [31:0] d1,
                                input logic [31:0] a2, input logic [31:0] d2);
        vec_t v;
        v.len = len; v.wid = wid; v.addr = addr; v.pix0 = p0; v.step = st;
        v.npix = np; v.nwords = nw; v.delay = dly; v.exp_stall = stall; v.restart = rs;
        v.exp_addr[0] = a0; v.exp_data[0] = d0;
        v.exp_addr[1] = a1; v.exp_data[1] = d1;
        v.exp_addr[2] = a2; v.exp_data[2] = d2;
        return v;
    endfunction

    // One image: start pulse, then per-cycle stimulus at the falling edge.
    task automatic run_vec(input vec_t v, input int id);
        int          idx = 0;
        int          words = 0;
        int          wcnt = 0;
        int          dones = 0;
        int          stalls = 0;
        int          cyc = 0;
        int          post = 0;
        int          done_cyc = -1;
        bit          inreq = 0;
        bit          stable_ok = 1;
        logic [31:0] hold_a = 32'd0;
        logic [31:0] hold_d = 32'd0;

        @(negedge HCLK);
        length = v.len; width = v.wid; out_addr = v.addr;
        start = 1'b1; pix_valid = 1'b0; wr_done = 1'b0;
        @(negedge HCLK);
        start = 1'b0;
        while (cyc < 400 && post < 3) begin
            if (v.restart && cyc == 0) begin
                start = 1'b1; length = 16'd20; width = 16'd20; out_addr = 32'h900;
            end else begin
                start = 1'b0;
            end
            pix_valid = 1'b1;
            pix_data  = v.pix0 + v.step * 8'(idx);
            if (busy && !pix_ready && idx < v.npix)
                stalls++;
            if (pix_ready)
                idx++;

            wr_done = 1'b0;
            if (wr_req) begin
                if (!inreq) begin
                    inreq = 1; wcnt = 0; hold_a = wr_addr; hold_d = wr_data;
                end else if (wr_addr !== hold_a || wr_data !== hold_d) begin
                    stable_ok = 0;
                end
                if (wcnt == v.delay) begin
                    if (words < 3) begin
                        check($sformatf("v%0d word%0d addr", id, words), hold_a, v.exp_addr[words]);
                        check($sformatf("v%0d word%0d data", id, words), hold_d, v.exp_data[words]);
                    end
                    words++;
                    wr_done = 1'b1;
                    inreq = 0;
                end
                wcnt++;
            end

            if (image_done) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (dones > 0) post++;
            cyc++;
            @(negedge HCLK);
        end
        pix_valid = 1'b0;
        wr_done   = 1'b0;
        start     = 1'b0;

        check($sformatf("v%0d timeout", id), 32'(cyc < 400), 32'd1);
        check($sformatf("v%0d word count", id), 32'(words), 32'(v.nwords));
        check($sformatf("v%0d pixels accepted", id), 32'(idx), 32'(v.npix));
        check($sformatf("v%0d image_done pulses", id), 32'(dones), 32'd1);
        check($sformatf("v%0d busy at end", id), 32'(busy), 32'd0);
        check($sformatf("v%0d addr/data stable", id), 32'(stable_ok), 32'd1);
        if (v.exp_stall)
            check($sformatf("v%0d pix_ready stalled", id), 32'(stalls > 0), 32'd1);
        if (v.npix == 0)
            check($sformatf("v%0d empty image latency", id), 32'(done_cyc >= 0 && done_cyc <= 1), 32'd1);
    endtask

    vec_t vecs[9];

    initial begin
        int idx;
        bit saw_req;

        vecs[0] = mk(16'd4,  16'd4, 32'h100,  8'h11, 8'h11, 4, 1, 1, 0, 1,
                     32'h100, 32'h44332211, 32'h0, 32'h0, 32'h0, 32'h0);
        vecs[1] = mk(16'd5,  16'd4, 32'h100,  8'h01, 8'h01, 6, 2, 1, 0, 0,
                     32'h100, 32'h04030201, 32'h104, 32'h00000605, 32'h0, 32'h0);
        vecs[2] = mk(16'd10, 16'd3, 32'h100,  8'h10, 8'h01, 8, 2, 5, 0, 0,
                     32'h100, 32'h13121110, 32'h104, 32'h17161514, 32'h0, 32'h0);
        vecs[3] = mk(16'd14, 16'd3, 32'h100,  8'h10, 8'h01, 12, 3, 5, 1, 0,
                     32'h100, 32'h13121110, 32'h104, 32'h17161514, 32'h108, 32'h1B1A1918);
        vecs[4] = mk(16'd3,  16'd3, 32'h1000, 8'hAB, 8'h00, 1, 1, 0, 0, 0,
                     32'h1000, 32'h000000AB, 32'h0, 32'h0, 32'h0, 32'h0);
        vecs[5] = mk(16'd7,  16'd3, 32'h43,   8'hA0, 8'h01, 5, 2, 2, 0, 0,
                     32'h40, 32'hA3A2A1A0, 32'h44, 32'h000000A4, 32'h0, 32'h0);
        vecs[6] = mk(16'd2,  16'd9, 32'h100,  8'h00, 8'h01, 0, 0, 0, 0, 1,
                     32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        vecs[7] = mk(16'd9,  16'd2, 32'h100,  8'h00, 8'h01, 0, 0, 0, 0, 0,
                     32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        vecs[8] = mk(16'd6,  16'd4, 32'h2000, 8'hF0, 8'h01, 8, 2, 0, 0, 0,
                     32'h2000, 32'hF3F2F1F0, 32'h2004, 32'hF7F6F5F4, 32'h0, 32'h0);

        HRESETn = 1'b0; out_addr = 32'd0; length = 16'd0; width = 16'd0;
        start = 1'b0; pix_valid = 1'b0; pix_data = 8'd0; wr_done = 1'b0;
        #1;
        check("reset pix_ready", 32'(pix_ready), 32'd0);
        check("reset wr_req", 32'(wr_req), 32'd0);
        check("reset wr_addr", wr_addr, 32'd0);
        check("reset wr_data", wr_data, 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset image_done", 32'(image_done), 32'd0);
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);
        check("idle after release busy", 32'(busy), 32'd0);

        for (int i = 0; i < 9; i++)
            run_vec(vecs[i], i);

        // Reset in the middle of an image while a write is pending.
        @(negedge HCLK);
        length = 16'd4; width = 16'd4; out_addr = 32'h300; start = 1'b1;
        @(negedge HCLK);
        start = 1'b0;
        idx = 0;
        saw_req = 0;
        for (int c = 0; c < 20 && !saw_req; c++) begin
            pix_valid = 1'b1;
            pix_data  = 8'h55 + 8'(idx);
            if (wr_req) saw_req = 1;
            else begin
                if (pix_ready) idx++;
                @(negedge HCLK);
            end
        end
        check("mid reset wr_req seen", 32'(saw_req), 32'd1);
        HRESETn = 1'b0;
        #1;
        check("mid reset wr_req", 32'(wr_req), 32'd0);
        check("mid reset busy", 32'(busy), 32'd0);
        check("mid reset pix_ready", 32'(pix_ready), 32'd0);
        check("mid reset wr_addr", wr_addr, 32'd0);
        check("mid reset wr_data", wr_data, 32'd0);
        pix_valid = 1'b0;
        @(negedge HCLK);
        HRESETn = 1'b1;
        run_vec(mk(16'd4, 16'd4, 32'h300, 8'h55, 8'h01, 4, 1, 1, 0, 0,
                   32'h300, 32'h58575655, 32'h0, 32'h0, 32'h0, 32'h0), 9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
